// File: rtl/ps2_keys_pkg.sv
// rtl/ps2_keys_pkg.sv - shared constants, prefix FSM states and key table for the PS/2 key tracker
//
// Purpose: scan-code prefix bytes, the prefix FSM state type and the fixed
// {ext, code} key table used by ps2_key_tracker.
// Ports: none (package).
// Configuration: PS2_EXTENDED_EN enables the E0 (extended) prefix states.
package ps2_keys_pkg;

   localparam logic [7:0] PS2_E0   = 8'hE0;
   localparam logic [7:0] PS2_F0   = 8'hF0;
   localparam int         MAX_KEYS = 10;

`ifdef PS2_EXTENDED_EN
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GOT_E0    = 2'd1,
      ST_GOT_F0    = 2'd2,
      ST_GOT_E0_F0 = 2'd3
   } prefix_state_e;
`else
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_GOT_F0 = 1'b1
   } prefix_state_e;
`endif

   // {ext, code}: W A S D X Up Down Left Right Enter
   localparam logic [0:MAX_KEYS-1][8:0] KEY_TABLE = {
      9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h022,
      9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A
   };

   typedef struct packed {
      logic       rel;
      logic [3:0] key;
   } key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - key event FIFO with count-based full/empty
//
// Purpose: DEPTH-entry queue of 5-bit key events (release flag + key index).
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   push_valid_i/_data_i write request and event
//   pop_ready_i         consumer accepts head (pop when head_valid_o too)
//   head_valid_o/_data_o head of queue; data forced to 0 while empty
//   overflow_o          sticky, set when a push is dropped on a full queue
module ps2_evt_fifo
   import ps2_keys_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     push_valid_i,
   input  key_evt_t push_data_i,
   input  logic     pop_ready_i,
   output logic     head_valid_o,
   output key_evt_t head_data_o,
   output logic     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   key_evt_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            full, do_push, do_pop;

   assign head_valid_o = (count_q != '0);
   assign full         = (count_q == CW'(DEPTH));
   assign do_pop       = head_valid_o && pop_ready_i;
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign do_push      = push_valid_i && (!full || do_pop);
   assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
   assign overflow_o   = overflow_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push_valid_i && !do_push) overflow_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the head is masked until count is non-zero.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 make/break/extended decoder with held-key mask and event queue
//
// Purpose: decodes PS/2 scan-code bytes against the package key table, keeps
// a held-key bitmask and queues press/release events.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   rx_data, rx_valid    received byte and one-cycle strobe
//   key_held             bit i set while table key i is held
//   evt_valid/evt_ready  event queue head handshake
//   evt_key, evt_release head event index and direction
//   evt_overflow         sticky: an event was dropped on a full queue
// Configuration: define PS2_EXTENDED_EN to decode E0-prefixed keys.
module ps2_key_tracker
   import ps2_keys_pkg::*;
#(
   parameter int NUM_KEYS  = 10,
   parameter int EVT_DEPTH = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [3:0]          evt_key,
   output logic                evt_release,
   output logic                evt_overflow
);

   prefix_state_e       state_q, state_d;
   logic [NUM_KEYS-1:0] key_held_q, key_held_d;
   logic                push_q, push_d;
   key_evt_t            push_evt_q, push_evt_d;
   key_evt_t            head_evt;
   logic                ext, brk;

   always_comb begin
      state_d    = state_q;
      key_held_d = key_held_q;
      push_d     = 1'b0;
      push_evt_d = push_evt_q;
      ext        = 1'b0;
      brk        = 1'b0;
      if (rx_valid) begin
         if (rx_data == PS2_E0) begin
`ifdef PS2_EXTENDED_EN
            state_d = ST_GOT_E0;
`endif
         end else if (rx_data == PS2_F0) begin
            case (state_q)
               ST_IDLE:   state_d = ST_GOT_F0;
`ifdef PS2_EXTENDED_EN
               ST_GOT_E0: state_d = ST_GOT_E0_F0;
`endif
               default:   state_d = state_q;
            endcase
         end else begin
`ifdef PS2_EXTENDED_EN
            ext = (state_q == ST_GOT_E0) || (state_q == ST_GOT_E0_F0);
            brk = (state_q == ST_GOT_F0) || (state_q == ST_GOT_E0_F0);
`else
            brk = (state_q == ST_GOT_F0);
`endif
            // Table entries are unique, so at most one index matches.
            for (int i = 0; i < NUM_KEYS; i++) begin
               if (KEY_TABLE[i] == {ext, rx_data}) begin
                  if (!brk && !key_held_q[i]) begin
                     key_held_d[i] = 1'b1;
                     push_d        = 1'b1;
                     push_evt_d    = '{rel: 1'b0, key: 4'(i)};
                  end else if (brk && key_held_q[i]) begin
                     key_held_d[i] = 1'b0;
                     push_d        = 1'b1;
                     push_evt_d    = '{rel: 1'b1, key: 4'(i)};
                  end
               end
            end
            state_d = ST_IDLE;
         end
      end
   end

   // The event is staged one cycle before entering the queue so it surfaces
   // the cycle after key_held changes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         key_held_q <= '0;
         push_q     <= 1'b0;
         push_evt_q <= '0;
      end else begin
         state_q    <= state_d;
         key_held_q <= key_held_d;
         push_q     <= push_d;
         push_evt_q <= push_evt_d;
      end
   end

   ps2_evt_fifo #(
      .DEPTH (EVT_DEPTH)
   ) u_evt_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_valid_i (push_q),
      .push_data_i  (push_evt_q),
      .pop_ready_i  (evt_ready),
      .head_valid_o (evt_valid),
      .head_data_o  (head_evt),
      .overflow_o   (evt_overflow)
   );

   assign key_held    = key_held_q;
   assign evt_key     = head_evt.key;
   assign evt_release = head_evt.rel;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [9:0] key_held;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] evt_key;
   logic       evt_release;
   logic       evt_overflow;

   int checks = 0;
   int errors = 0;

   logic       v;
   logic [3:0] k;
   logic       r;

   always #5 clock = ~clock;

   ps2_key_tracker #(
      .NUM_KEYS  (10),
      .EVT_DEPTH (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .key_held     (key_held),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_key      (evt_key),
      .evt_release  (evt_release),
      .evt_overflow (evt_overflow)
   );

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pop_event(output logic pv, output logic [3:0] pk, output logic pr);
      pv = evt_valid;
      pk = evt_key;
      pr = evt_release;
      evt_ready = 1'b1;
      @(negedge clock);
      evt_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; evt_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      checks++;
      if (key_held !== 10'h000) begin errors++; $display("FAIL reset_key_held: got %h expected %h", key_held, 10'h000); end
      checks++;
      if ({evt_valid, evt_key, evt_release, evt_overflow} !== 7'h00) begin
         errors++; $display("FAIL reset_evt: got %h expected %h", {evt_valid, evt_key, evt_release, evt_overflow}, 7'h00);
      end
   endtask

   task automatic test_press_release();
      send_byte(8'h1D);
      checks++;
      if ({key_held, evt_valid} !== {10'h001, 1'b0}) begin
         errors++; $display("FAIL press_latency: got %h expected %h", {key_held, evt_valid}, {10'h001, 1'b0});
      end
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL press_event: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b0}); end
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL press_single: got %b expected 0", evt_valid); end
      send_byte(8'hF0); send_byte(8'h1D);
      checks++;
      if (key_held !== 10'h000) begin errors++; $display("FAIL release_held: got %h expected %h", key_held, 10'h000); end
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL release_event: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b1}); end
   endtask

   task automatic test_repeat();
      send_byte(8'h1D); send_byte(8'h1D); send_byte(8'h1D);
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL repeat_first: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b0}); end
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL repeat_extra_event: got %b expected 0", evt_valid); end
      send_byte(8'hF0); send_byte(8'h22);
      settle();
      checks++;
      if ({key_held, evt_valid} !== {10'h001, 1'b0}) begin
         errors++; $display("FAIL release_not_held: got %h expected %h", {key_held, evt_valid}, {10'h001, 1'b0});
      end
      send_byte(8'hF0); send_byte(8'h1D);
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL repeat_release: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b1}); end
   endtask

   task automatic test_extended();
      send_byte(8'hE0); send_byte(8'h75);
      settle();
`ifdef PS2_EXTENDED_EN
      checks++;
      if (key_held !== 10'h020) begin errors++; $display("FAIL ext_press_held: got %h expected %h", key_held, 10'h020); end
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd5, 1'b0}) begin errors++; $display("FAIL ext_press_event: got %h expected %h", {v, k, r}, {1'b1, 4'd5, 1'b0}); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      settle();
      checks++;
      if (key_held !== 10'h000) begin errors++; $display("FAIL ext_release_held: got %h expected %h", key_held, 10'h000); end
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd5, 1'b1}) begin errors++; $display("FAIL ext_release_event: got %h expected %h", {v, k, r}, {1'b1, 4'd5, 1'b1}); end
`else
      checks++;
      if ({key_held, evt_valid} !== 11'h000) begin errors++; $display("FAIL noext_press: got %h expected %h", {key_held, evt_valid}, 11'h000); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      settle();
      checks++;
      if ({key_held, evt_valid} !== 11'h000) begin errors++; $display("FAIL noext_release: got %h expected %h", {key_held, evt_valid}, 11'h000); end
`endif
      // F0 followed by E0 before a table code that exists only without ext
      send_byte(8'h1D);
      settle();
      pop_event(v, k, r);
      send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h1D);
      settle();
`ifdef PS2_EXTENDED_EN
      checks++;
      if ({key_held, evt_valid} !== {10'h001, 1'b0}) begin
         errors++; $display("FAIL ext_f0_e0: got %h expected %h", {key_held, evt_valid}, {10'h001, 1'b0});
      end
      send_byte(8'hF0); send_byte(8'h1D);
      settle();
      pop_event(v, k, r);
`else
      pop_event(v, k, r);
      checks++;
      if ({key_held, v, k, r} !== {10'h000, 1'b1, 4'd0, 1'b1}) begin
         errors++; $display("FAIL noext_e0_ignored: got %h expected %h", {key_held, v, k, r}, {10'h000, 1'b1, 4'd0, 1'b1});
      end
`endif
   endtask

   task automatic test_back_to_back();
      @(negedge clock); rx_data = 8'h1D; rx_valid = 1'b1;
      @(negedge clock); rx_data = 8'h1C;
      @(negedge clock); rx_valid = 1'b0;
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL b2b_first: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b0}); end
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL b2b_second: got %h expected %h", {v, k, r}, {1'b1, 4'd1, 1'b0}); end
      @(negedge clock); rx_data = 8'hF0; rx_valid = 1'b1;
      @(negedge clock); rx_data = 8'h1D;
      @(negedge clock); rx_data = 8'hF0;
      @(negedge clock); rx_data = 8'h1C;
      @(negedge clock); rx_valid = 1'b0;
      settle();
      checks++;
      if (key_held !== 10'h000) begin errors++; $display("FAIL b2b_held: got %h expected %h", key_held, 10'h000); end
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL b2b_rel_first: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b1}); end
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL b2b_rel_second: got %h expected %h", {v, k, r}, {1'b1, 4'd1, 1'b1}); end
   endtask

   task automatic test_empty_push_pop();
      send_byte(8'h1C);
      evt_ready = 1'b1;
      @(negedge clock);
      evt_ready = 1'b0;
      checks++;
      if ({evt_valid, evt_key, evt_release} !== {1'b1, 4'd1, 1'b0}) begin
         errors++; $display("FAIL empty_push_pop: got %h expected %h", {evt_valid, evt_key, evt_release}, {1'b1, 4'd1, 1'b0});
      end
      pop_event(v, k, r);
      send_byte(8'hF0); send_byte(8'h1C);
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r, evt_valid} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL empty_cleanup: got %h expected %h", {v, k, r, evt_valid}, {1'b1, 4'd1, 1'b1, 1'b0});
      end
   endtask

   task automatic test_overflow();
      logic [7:0] seq [13] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h22, 8'hF0, 8'h1D, 8'hF0, 8'h1C, 8'hF0, 8'h1B, 8'hF0, 8'h23};
      logic [3:0] ek [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2};
      logic       er [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      evt_ready = 1'b0;
      for (int i = 0; i < 13; i++) send_byte(seq[i]);
      settle(); settle();
      checks++;
      if ({evt_overflow, key_held} !== {1'b1, 10'h010}) begin
         errors++; $display("FAIL overflow_flag: got %h expected %h", {evt_overflow, key_held}, {1'b1, 10'h010});
      end
      for (int i = 0; i < 8; i++) begin
         pop_event(v, k, r);
         checks++;
         if ({v, k, r} !== {1'b1, ek[i], er[i]}) begin
            errors++; $display("FAIL overflow_drain_%0d: got %h expected %h", i, {v, k, r}, {1'b1, ek[i], er[i]});
         end
      end
      checks++;
      if ({evt_valid, evt_overflow} !== 2'b01) begin
         errors++; $display("FAIL overflow_after_drain: got %b expected %b", {evt_valid, evt_overflow}, 2'b01);
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'hE0); send_byte(8'hF0);
      do_reset();
      checks++;
      if ({key_held, evt_valid, evt_overflow} !== 12'h000) begin
         errors++; $display("FAIL mid_reset_state: got %h expected %h", {key_held, evt_valid, evt_overflow}, 12'h000);
      end
      send_byte(8'h75);
      settle();
      checks++;
      if ({key_held, evt_valid} !== 11'h000) begin errors++; $display("FAIL mid_reset_75: got %h expected %h", {key_held, evt_valid}, 11'h000); end
      send_byte(8'hF0);
      do_reset();
      send_byte(8'h1D);
      settle();
      pop_event(v, k, r);
      checks++;
      if ({v, k, r} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL mid_reset_f0: got %h expected %h", {v, k, r}, {1'b1, 4'd0, 1'b0}); end
      send_byte(8'hAA);
      settle();
      checks++;
      if ({key_held, evt_valid} !== {10'h001, 1'b0}) begin
         errors++; $display("FAIL unknown_byte: got %h expected %h", {key_held, evt_valid}, {10'h001, 1'b0});
      end
   endtask

   task automatic test_full_concurrent();
      logic [7:0] seq [11] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h22, 8'hF0, 8'h1D, 8'hF0, 8'h1C, 8'hF0, 8'h1B};
      logic [3:0] ek [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3};
      logic       er [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      evt_ready = 1'b0;
      for (int i = 0; i < 11; i++) send_byte(seq[i]);
      settle();
      checks++;
      if ({evt_valid, evt_key, evt_release, evt_overflow} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL full_head: got %h expected %h", {evt_valid, evt_key, evt_release, evt_overflow}, {1'b1, 4'd0, 1'b0, 1'b0});
      end
      send_byte(8'hF0); send_byte(8'h23);
      evt_ready = 1'b1;
      @(negedge clock);
      evt_ready = 1'b0;
      checks++;
      if (evt_overflow !== 1'b0) begin errors++; $display("FAIL full_concurrent_overflow: got %b expected 0", evt_overflow); end
      for (int i = 0; i < 8; i++) begin
         pop_event(v, k, r);
         checks++;
         if ({v, k, r} !== {1'b1, ek[i], er[i]}) begin
            errors++; $display("FAIL full_concurrent_drain_%0d: got %h expected %h", i, {v, k, r}, {1'b1, ek[i], er[i]});
         end
      end
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_concurrent_count: got %b expected 0", evt_valid); end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_repeat();
      test_extended();
      test_back_to_back();
      test_empty_push_pop();
      test_overflow();
      test_reset_mid();
      test_full_concurrent();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
